// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use stall detection.
// Feeds the ALU operands and control directly from the forwarded, latched fields.
module id_ex_stage #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  id_alu_src,
  input  logic [3:0]            id_alu_control,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  ex_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic [DATA_W-1:0]     ex_mem_alu_out,
  input  logic                  mem_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic [DATA_W-1:0]     mem_wb_wdata,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [3:0]            alu_control,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic                  stall_id
);

  logic                  r_valid, r_reg_write, r_mem_read, r_mem_write, r_branch, r_alu_src;
  logic [3:0]            r_alu_control;
  logic [REG_ADDR_W-1:0] r_rs, r_rt, r_rd;
  logic [DATA_W-1:0]     r_rs_data, r_rt_data, r_imm;

  logic                  w_stall;
  logic                  w_bubble;
  logic [DATA_W-1:0]     w_fwd_rs, w_fwd_rt;

  // Load-use: the load's data is not available until it reaches MEM/WB.
  always_comb begin
    w_stall = ~flush & r_valid & r_mem_read & id_valid & (r_rd != '0) &
              ((id_uses_rs & (r_rd == id_rs)) | (id_uses_rt & (r_rd == id_rt)));
  end

  // Freeze outranks a stall bubble, but not reset or flush.
  assign w_bubble = rst | flush | (~freeze & w_stall);

  always_ff @(posedge clk) begin
    if (w_bubble) begin
      r_valid       <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_branch      <= 1'b0;
      r_alu_src     <= 1'b0;
      r_alu_control <= '0;
      r_rs          <= '0;
      r_rt          <= '0;
      r_rd          <= '0;
      r_rs_data     <= '0;
      r_rt_data     <= '0;
      r_imm         <= '0;
    end else if (!freeze) begin
      r_valid       <= id_valid;
      r_reg_write   <= id_valid & id_reg_write;
      r_mem_read    <= id_valid & id_mem_read;
      r_mem_write   <= id_valid & id_mem_write;
      r_branch      <= id_valid & id_branch;
      r_alu_src     <= id_valid & id_alu_src;
      r_alu_control <= id_valid ? id_alu_control : 4'b0000;
      r_rs          <= id_rs;
      r_rt          <= id_rt;
      r_rd          <= id_rd;
      r_rs_data     <= id_rs_data;
      r_rt_data     <= id_rt_data;
      r_imm         <= id_imm;
    end
  end

  // Youngest producer wins; register 0 always reads as zero.
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (r_rs == '0)                                   w_fwd_rs = '0;
    else if (ex_mem_reg_write && (ex_mem_rd == r_rs)) w_fwd_rs = ex_mem_alu_out;
    else if (mem_wb_reg_write && (mem_wb_rd == r_rs)) w_fwd_rs = mem_wb_wdata;
  end

  always_comb begin
    w_fwd_rt = r_rt_data;
    if (r_rt == '0)                                   w_fwd_rt = '0;
    else if (ex_mem_reg_write && (ex_mem_rd == r_rt)) w_fwd_rt = ex_mem_alu_out;
    else if (mem_wb_reg_write && (mem_wb_rd == r_rt)) w_fwd_rt = mem_wb_wdata;
  end

  assign alu_a         = w_fwd_rs;
  assign alu_b         = r_alu_src ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign alu_control   = r_alu_control;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_branch     = r_branch;
  assign ex_rd         = r_rd;
  assign stall_id      = w_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios plus random traffic against a
// transaction-level model of the instruction sitting in EX.
module tb_id_ex_stage;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_valid, id_uses_rs, id_uses_rt, id_alu_src;
  logic [AW-1:0] id_rs, id_rt, id_rd, ex_mem_rd, mem_wb_rd;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm, ex_mem_alu_out, mem_wb_wdata;
  logic [3:0]    id_alu_control;
  logic          id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic          freeze, flush, ex_mem_reg_write, mem_wb_reg_write;
  logic [DW-1:0] alu_a, alu_b, ex_store_data;
  logic [3:0]    alu_control;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, stall_id;
  logic [AW-1:0] ex_rd;

  id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alu_src(id_alu_src),
    .id_alu_control(id_alu_control), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch), .freeze(freeze), .flush(flush),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd), .ex_mem_alu_out(ex_mem_alu_out),
    .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd), .mem_wb_wdata(mem_wb_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_rd(ex_rd), .ex_store_data(ex_store_data), .stall_id(stall_id)
  );

  // The instruction the model believes is in EX.
  typedef struct packed {
    logic          valid, reg_write, mem_read, mem_write, branch, alu_src;
    logic [3:0]    ctl;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] rs_data, rt_data, imm;
  } instr_t;

  instr_t m;
  bit     m_known = 1'b0;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] operand(input logic [AW-1:0] s, input logic [DW-1:0] rf);
    if (s == 0) return '0;
    if (ex_mem_reg_write && ex_mem_rd == s) return ex_mem_alu_out;
    if (mem_wb_reg_write && mem_wb_rd == s) return mem_wb_wdata;
    return rf;
  endfunction

  function automatic bit hazard();
    bit dep;
    dep = (id_uses_rs && id_rs == m.rd) || (id_uses_rt && id_rt == m.rd);
    return !flush && m.valid && m.mem_read && id_valid && m.rd != 0 && dep;
  endfunction

  task automatic compare_all();
    chk("stall_id", {15'b0, stall_id}, {15'b0, hazard()});
    chk("ex_valid", {15'b0, ex_valid}, {15'b0, m.valid});
    chk("ex_reg_write", {15'b0, ex_reg_write}, {15'b0, m.reg_write});
    chk("ex_mem_read", {15'b0, ex_mem_read}, {15'b0, m.mem_read});
    chk("ex_mem_write", {15'b0, ex_mem_write}, {15'b0, m.mem_write});
    chk("ex_branch", {15'b0, ex_branch}, {15'b0, m.branch});
    chk("ex_rd", {13'b0, ex_rd}, {13'b0, m.rd});
    chk("alu_control", {12'b0, alu_control}, {12'b0, m.ctl});
    chk("alu_a", alu_a, operand(m.rs, m.rs_data));
    chk("alu_b", alu_b, m.alu_src ? m.imm : operand(m.rt, m.rt_data));
    chk("ex_store_data", ex_store_data, operand(m.rt, m.rt_data));
  endtask

  task automatic model_edge();
    instr_t nxt;
    bit haz;
    haz = hazard();
    nxt = '0;
    if (rst || flush) m = '0;
    else if (freeze) m = m;
    else if (haz) m = '0;
    else begin
      nxt.valid   = id_valid;
      nxt.rs      = id_rs;
      nxt.rt      = id_rt;
      nxt.rd      = id_rd;
      nxt.rs_data = id_rs_data;
      nxt.rt_data = id_rt_data;
      nxt.imm     = id_imm;
      if (id_valid) begin
        nxt.reg_write = id_reg_write;
        nxt.mem_read  = id_mem_read;
        nxt.mem_write = id_mem_write;
        nxt.branch    = id_branch;
        nxt.alu_src   = id_alu_src;
        nxt.ctl       = id_alu_control;
      end
      m = nxt;
    end
    if (rst) m_known = 1'b1;
  endtask

  // Compare mid-cycle, then advance one edge; returns at posedge + 1.
  task automatic step();
    @(negedge clk);
    #1;
    if (m_known) compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; freeze = 0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alu_src = 0; id_alu_control = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_branch = 0;
    ex_mem_reg_write = 0; ex_mem_rd = 0; ex_mem_alu_out = 0;
    mem_wb_reg_write = 0; mem_wb_rd = 0; mem_wb_wdata = 0;
  endtask

  task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic [DW-1:0] rsd,
                       input logic [DW-1:0] rtd, input logic [3:0] ctl);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rs = 1; id_uses_rt = 1;
    id_rs_data = rsd; id_rt_data = rtd; id_alu_control = ctl; id_reg_write = 1;
    id_alu_src = 0; id_imm = 0; id_mem_read = 0; id_mem_write = 0; id_branch = 0;
  endtask

  task automatic issue_load(input logic [AW-1:0] rd);
    issue(3'd1, 3'd0, rd, 16'h0100, 16'h0, 4'b0010);
    id_uses_rt = 0; id_alu_src = 1; id_imm = 16'h0004; id_mem_read = 1;
  endtask

  initial begin
    idle_inputs();

    // Reset with busy decode inputs
    rst = 1;
    issue(3'd1, 3'd2, 3'd3, 16'hAAAA, 16'h5555, 4'b0110);
    id_mem_read = 1; id_branch = 1;
    step();
    step();
    chk("rst_valid", {15'b0, ex_valid}, 16'h0);
    chk("rst_ctl", {12'b0, alu_control}, 16'h0);
    chk("rst_a", alu_a, 16'h0);
    chk("rst_b", alu_b, 16'h0);
    chk("rst_stall", {15'b0, stall_id}, 16'h0);
    rst = 0;

    // Plain ADD
    idle_inputs();
    issue(3'd1, 3'd2, 3'd3, 16'h0005, 16'h0003, 4'b0010);
    step();
    chk("add_a", alu_a, 16'h0005);
    chk("add_b", alu_b, 16'h0003);
    chk("add_ctl", {12'b0, alu_control}, 16'h0002);

    // Both forwarding sources hit r2: EX/MEM is younger
    issue(3'd2, 3'd4, 3'd5, 16'h7777, 16'h0009, 4'b0001);
    ex_mem_reg_write = 1; ex_mem_rd = 2; ex_mem_alu_out = 16'h1111;
    mem_wb_reg_write = 1; mem_wb_rd = 2; mem_wb_wdata = 16'h2222;
    step();
    chk("dbl_a", alu_a, 16'h1111);
    issue(3'd0, 3'd4, 3'd5, 16'h5555, 16'h0009, 4'b0001);
    ex_mem_rd = 0; mem_wb_rd = 0;
    step();
    chk("r0_a", alu_a, 16'h0000);

    // Load-use: LW r3 then SUB r5 = r3 - r1
    idle_inputs();
    issue_load(3'd3);
    step();
    issue(3'd3, 3'd1, 3'd5, 16'h0000, 16'h0010, 4'b0110);
    #1;
    chk("lu_stall", {15'b0, stall_id}, 16'h1);
    step();
    chk("lu_bubble", {15'b0, ex_valid}, 16'h0);
    chk("lu_stall_drop", {15'b0, stall_id}, 16'h0);
    mem_wb_reg_write = 1; mem_wb_rd = 3; mem_wb_wdata = 16'hBEEF;
    step();
    chk("lu_valid", {15'b0, ex_valid}, 16'h1);
    chk("lu_a", alu_a, 16'hBEEF);
    chk("lu_ctl", {12'b0, alu_control}, 16'h0006);

    // Store: immediate on B, forwarded rt on store data
    idle_inputs();
    issue(3'd1, 3'd6, 3'd0, 16'h0040, 16'h0000, 4'b0010);
    id_reg_write = 0; id_alu_src = 1; id_imm = 16'hFFFC; id_mem_write = 1;
    ex_mem_reg_write = 1; ex_mem_rd = 6; ex_mem_alu_out = 16'h00AA;
    step();
    chk("sw_b", alu_b, 16'hFFFC);
    chk("sw_store", ex_store_data, 16'h00AA);
    chk("sw_mw", {15'b0, ex_mem_write}, 16'h1);

    // Flush + freeze with a pending load-use hazard
    idle_inputs();
    issue_load(3'd3);
    step();
    issue(3'd3, 3'd2, 3'd4, 16'h0, 16'h0, 4'b0000);
    flush = 1; freeze = 1;
    #1;
    chk("ff_stall", {15'b0, stall_id}, 16'h0);
    step();
    chk("ff_bubble", {15'b0, ex_valid}, 16'h0);

    // Freeze alone holds the EX instruction
    idle_inputs();
    issue(3'd1, 3'd2, 3'd4, 16'h1234, 16'h4321, 4'b0001);
    step();
    issue(3'd5, 3'd6, 3'd7, 16'hDEAD, 16'hF00D, 4'b1100);
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_valid", {15'b0, ex_valid}, 16'h1);
      chk("frz_rd", {13'b0, ex_rd}, 16'h0004);
      chk("frz_ctl", {12'b0, alu_control}, 16'h0001);
      chk("frz_a", alu_a, 16'h1234);
      chk("frz_b", alu_b, 16'h4321);
    end
    freeze = 0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst              = ($urandom_range(63) == 0);
      flush            = ($urandom_range(15) == 0);
      freeze           = ($urandom_range(7) == 0);
      id_valid         = ($urandom_range(3) != 0);
      id_rs            = AW'($urandom_range(7));
      id_rt            = AW'($urandom_range(7));
      id_rd            = AW'($urandom_range(7));
      id_uses_rs       = 1'($urandom_range(1));
      id_uses_rt       = 1'($urandom_range(1));
      id_rs_data       = DW'($urandom);
      id_rt_data       = DW'($urandom);
      id_imm           = DW'($urandom);
      id_alu_src       = 1'($urandom_range(1));
      id_alu_control   = 4'($urandom_range(15));
      id_reg_write     = 1'($urandom_range(1));
      id_mem_read      = 1'($urandom_range(1));
      id_mem_write     = 1'($urandom_range(1));
      id_branch        = 1'($urandom_range(1));
      ex_mem_reg_write = 1'($urandom_range(1));
      ex_mem_rd        = AW'($urandom_range(7));
      ex_mem_alu_out   = DW'($urandom);
      mem_wb_reg_write = 1'($urandom_range(1));
      mem_wb_rd        = AW'($urandom_range(7));
      mem_wb_wdata     = DW'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
